multicycle_control: RTL and testbench

- Moore-style control FSM for the multicycle MIPS datapath.
- Sequences one shared ALU through fetch, decode, execute, memory and writeback steps.
- Drives ALUOp into the existing ALU decoder: 00 = add, 01 = subtract, 10 = use Funct.
- Handles a ready handshake to instruction/data memory and an optional multi-cycle multiply wait.

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Optional multi-cycle multiply wait state is built only when MUL_MULTICYCLE_EN is defined.
module multicycle_control #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    MULWAIT = 4'd12
  } state_e;

  state_e state_q, state_d;

`ifdef MUL_MULTICYCLE_EN
  localparam logic [5:0] FUNCT_MUL = 6'b011100;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Funct only steers the multiply path, which is not built here.
  logic unused_funct;
  assign unused_funct = ^Funct;
`endif

  // State and multiply counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
`ifdef MUL_MULTICYCLE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MUL_MULTICYCLE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
`ifdef MUL_MULTICYCLE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXECUTE: begin
        state_d = ALUWB;
`ifdef MUL_MULTICYCLE_EN
        if (Op == OP_RTYPE && Funct == FUNCT_MUL) begin
          state_d = MULWAIT;
          cnt_d   = CNT_W'(MUL_LATENCY - 1);
        end
`endif
      end
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef MUL_MULTICYCLE_EN
      MULWAIT: begin
        if (cnt_q == '0) begin
          state_d = ALUWB;
        end else begin
          state_d = MULWAIT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; only mem_ready (FETCH) and Zero (BRANCH) pass through combinationally
  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = Zero;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
`ifdef MUL_MULTICYCLE_EN
      MULWAIT: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state traces with a scoreboard
// of expected state/output words, plus a hand-written asynchronous reset sequence.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [63:0] trace;  // state for cycle i at bits [4*i +: 4]
    logic [15:0] mr;     // mem_ready for cycle i (handshake states only)
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] sb[$];

  // Reference output word {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn}
  function automatic logic [14:0] exp_out(input logic [3:0] st, input logic mr, input logic z);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcen;
    logic [1:0] srcb, aop, pcs;
    {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcen} = '0;
    {srcb, aop, pcs} = '0;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      4'd9:  begin srca = 1; srcb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pcs = 2'b10; pcen = 1; end
      4'd12: begin srca = 1; aop = 2'b10; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, pcen};
  endfunction

  function automatic logic [18:0] dut_word();
    return {State, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCEn};
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int len, input logic [63:0] tr,
                              input logic [15:0] mr);
    vec_t v;
    v.name = n; v.op = op; v.funct = fn; v.zero = z; v.len = len; v.trace = tr; v.mr = mr;
    return v;
  endfunction

  initial begin
    logic [3:0]  st;
    logic        m;
    logic [18:0] e;

    vecs.push_back(mk("lw",        6'b100011, 6'h00, 1'b0, 5, 64'h43210,    16'hFFFF));
    vecs.push_back(mk("lw_stall",  6'b100011, 6'h00, 1'b0, 8, 64'h43333210, 16'hFFC7));
    vecs.push_back(mk("sw_stall",  6'b101011, 6'h00, 1'b0, 6, 64'h555210,   16'hFFE7));
    vecs.push_back(mk("sw",        6'b101011, 6'h00, 1'b1, 4, 64'h5210,     16'hFFFF));
    vecs.push_back(mk("add",       6'b000000, 6'b100000, 1'b0, 4, 64'h7610, 16'hFFFF));
    vecs.push_back(mk("beq_taken", 6'b000100, 6'h00, 1'b1, 3, 64'h810,      16'hFFFF));
    vecs.push_back(mk("beq_not",   6'b000100, 6'h00, 1'b0, 3, 64'h810,      16'hFFFF));
    vecs.push_back(mk("addi",      6'b001000, 6'h00, 1'b0, 4, 64'hA910,     16'hFFFF));
    vecs.push_back(mk("j",         6'b000010, 6'h00, 1'b0, 3, 64'hB10,      16'hFFFF));
    vecs.push_back(mk("nop_op",    6'b111111, 6'h00, 1'b1, 2, 64'h10,       16'hFFFF));
    vecs.push_back(mk("fetch_stall", 6'b111111, 6'h00, 1'b0, 4, 64'h1000,   16'hFFFC));
`ifdef MUL_MULTICYCLE_EN
    vecs.push_back(mk("mul",       6'b000000, 6'b011100, 1'b0, 8, 64'h7CCCC610, 16'hFFFF));
`else
    vecs.push_back(mk("mul",       6'b000000, 6'b011100, 1'b0, 4, 64'h7610, 16'hFFFF));
`endif

    // Reset state
    rst = 1'b1; mem_ready = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    @(negedge clk); #1;
    chk("reset_state", dut_word(), {4'd0, exp_out(4'd0, 1'b1, 1'b0)});
    @(negedge clk);
    rst = 1'b0;

    // Table-driven instruction traces
    foreach (vecs[vi]) begin
      for (int i = 0; i < vecs[vi].len; i++) begin
        if (i != 0) @(negedge clk);
        st = vecs[vi].trace[4*i +: 4];
        m  = (st == 4'd0 || st == 4'd3 || st == 4'd5) ? vecs[vi].mr[i] : 1'($urandom_range(0, 1));
        Op = vecs[vi].op; Funct = vecs[vi].funct; Zero = vecs[vi].zero; mem_ready = m;
        sb.push_back({st, exp_out(st, m, vecs[vi].zero)});
        #1;
        e = sb.pop_front();
        chk($sformatf("%s_c%0d", vecs[vi].name, i), dut_word(), e);
      end
      @(negedge clk);
    end
    #1;
    chk("back_to_fetch", 19'(State), 19'd0);

    // Asynchronous reset in the middle of a stalled MEMRD
    Op = 6'b100011; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    #1;
    chk("pre_reset_memrd", 19'(State), 19'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 19'(State), 19'd0);
    chk("async_rst_regwrite", 19'(RegWrite), 19'd0);
    chk("async_rst_outputs", dut_word(), {4'd0, exp_out(4'd0, 1'b0, 1'b0)});
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk("post_rst_irwrite", 19'(IRWrite), 19'd1);
    chk("post_rst_pcen", 19'(PCEn), 19'd1);
    @(negedge clk); #1;
    chk("post_rst_decode", 19'(State), 19'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
